// File: rtl/wb_cam_pkg.sv
// wb_cam_pkg: register offsets, bit positions, entry width and reset values
// shared by wb_cam_capture and its bench.
package wb_cam_pkg;
  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h1;
  localparam logic [3:0] OFF_DATA   = 4'h2;
  localparam logic [3:0] OFF_THRESH = 4'h3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;
  localparam int ST_SOF   = 3;
  localparam int ST_UNF   = 4;

  localparam int PIX_W_DFLT = 16;
  localparam int ENTRY_W    = PIX_W_DFLT + 1;

  // Field order matches STATUS[4:2] so the W1C mask applies directly.
  typedef struct packed {
    logic unf;
    logic sof;
    logic ovf;
  } sticky_t;

  localparam sticky_t     STICKY_RST = '0;
  localparam logic [15:0] THRESH_RST = 16'h0;
endpackage

// File: rtl/cam_sync_fifo.sv
// cam_sync_fifo: single-clock FIFO with flush; head entry is combinational
// from the array so the parent can register it on a read.
module cam_sync_fifo #(
  parameter int DEPTH = 512,
  parameter int WIDTH = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; reads are masked by empty in the parent.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/wb_cam_capture.sv
// wb_cam_capture: Wishbone slave buffering an RGB565 pixel stream in a FIFO.
// Define WB_CAM_IRQ_EN to build the threshold/overflow interrupt.
module wb_cam_capture
  import wb_cam_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int PIX_W = PIX_W_DFLT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  input  logic             pix_valid_i,
  input  logic [PIX_W-1:0] pix_data_i,
  input  logic             pix_sof_i,
  output logic             pix_ready_o,
  output logic             irq_o
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int EW = PIX_W + 1;

  logic          ack_q, ack_d, irq_q, irq_d;
  logic          en_q, en_d, irq_en_q, irq_en_d;
  logic [31:0]   dat_q, dat_d, rdata;
  logic [15:0]   thresh_q, thresh_d;
  sticky_t       sticky_q, sticky_d;
  logic          req, wr, rd, push, pop, flush, full, empty;
  logic [3:0]    off;
  logic [LW-1:0] level;
  logic [EW-1:0] head;
  logic          unused_ok;

  assign req   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign off   = wb_adr_i[5:2];
  assign wr    = req & wb_we_i;
  assign rd    = req & ~wb_we_i;
  assign flush = wr & (off == OFF_CTRL) & wb_sel_i[0] & wb_dat_i[CTRL_FLUSH];
  assign pop   = rd & (off == OFF_DATA) & ~empty;
  // Pre-pop full: a pixel arriving with a DATA pop on a full FIFO is dropped.
  assign push  = pix_valid_i & en_q & ~full;

  cam_sync_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({pix_sof_i, pix_data_i}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_comb begin
    rdata = '0;
    case (off)
      OFF_CTRL: begin
        rdata[CTRL_EN]     = en_q;
        rdata[CTRL_IRQ_EN] = irq_en_q;
      end
      OFF_STATUS: rdata = {16'(level), 11'b0, sticky_q, full, empty};
      OFF_DATA:   if (!empty) rdata = 32'(head);
      OFF_THRESH: rdata = {16'b0, thresh_q};
      default:    rdata = '0;
    endcase
  end

  always_comb begin
    ack_d    = req;
    dat_d    = req ? rdata : dat_q;
    en_d     = en_q;
    irq_en_d = irq_en_q;
    thresh_d = thresh_q;
    irq_d    = 1'b0;
    sticky_d = sticky_q;
    if (wr && off == OFF_CTRL && wb_sel_i[0]) begin
      en_d     = wb_dat_i[CTRL_EN];
      irq_en_d = wb_dat_i[CTRL_IRQ_EN];
    end
    if (wr && off == OFF_THRESH) begin
      if (wb_sel_i[0]) thresh_d[7:0]  = wb_dat_i[7:0];
      if (wb_sel_i[1]) thresh_d[15:8] = wb_dat_i[15:8];
    end
    if (wr && off == OFF_STATUS)
      sticky_d = sticky_t'(sticky_q & ~wb_dat_i[ST_UNF:ST_OVF]);
    // Sets come after the clear so an event in the W1C cycle is kept.
    if (pix_valid_i && en_q && full)         sticky_d.ovf = 1'b1;
    if (push && !flush && pix_sof_i)         sticky_d.sof = 1'b1;
    if (rd && off == OFF_DATA && empty)      sticky_d.unf = 1'b1;
`ifdef WB_CAM_IRQ_EN
    irq_d = irq_en_q & (((thresh_q != '0) & (16'(level) >= thresh_q)) | sticky_q.ovf);
`else
    irq_en_d = 1'b0;
    thresh_d = '0;
`endif
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_q    <= 1'b0;
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      thresh_q <= THRESH_RST;
      sticky_q <= STICKY_RST;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      irq_q    <= irq_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      thresh_q <= thresh_d;
      sticky_q <= sticky_d;
    end
  end

  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = 1'b0;
  assign wb_rty_o    = 1'b0;
  assign irq_o       = irq_q;
  assign pix_ready_o = en_q & ~full;

  assign unused_ok = ^{wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i, wb_sel_i, wb_cti_i, wb_bte_i};
endmodule

// File: tb/tb_wb_cam_capture.sv
// tb_wb_cam_capture: randomized scoreboard bench; a queue-based model predicts
// every read, the interrupt and pix_ready; a monitor checks on each ack.
module tb_wb_cam_capture;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dati, dato;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err, rty;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        pv, psof, pready, irq;
  logic [15:0] pd;

  always #5 clk = ~clk;

  wb_cam_capture #(.DEPTH(DEPTH), .PIX_W(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dati),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_cti_i(cti), .wb_bte_i(bte), .wb_dat_o(dato), .wb_ack_o(ack),
    .wb_err_o(err), .wb_rty_o(rty), .pix_valid_i(pv), .pix_data_i(pd),
    .pix_sof_i(psof), .pix_ready_o(pready), .irq_o(irq)
  );

  int vectors = 0, miscompares = 0;
  int bg_rate = 0;
  bit mon_en = 1'b0;
  bit req_at_edge = 1'b0;

  // Reference model: FIFO as a queue plus flat register state.
  logic [16:0] mq[$];
  bit          m_en, m_irq_en, m_ovf, m_sof, m_unf, m_irq;
  bit [15:0]   m_thresh;

  typedef struct {
    bit          is_rd;
    logic [31:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(logic [3:0] off);
    case (off)
      4'h0: return {29'b0, m_irq_en, 1'b0, m_en};
      4'h1: return {16'(mq.size()), 11'b0, m_unf, m_sof, m_ovf,
                    mq.size() == DEPTH, mq.size() == 0};
      4'h2: return (mq.size() == 0) ? 32'h0 : {15'b0, mq[0]};
      4'h3: return {16'b0, m_thresh};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_en = 0; m_irq_en = 0; m_ovf = 0; m_sof = 0; m_unf = 0; m_irq = 0;
    m_thresh = '0;
  endfunction

  function automatic bit bg_v();
    return $urandom_range(99) < bg_rate;
  endfunction

  // One clock: drive inputs, predict, advance the model at the edge.
  task automatic step(bit bus, bit w, logic [3:0] off, logic [31:0] d, logic [3:0] s,
                      bit v, bit sf, logic [15:0] px);
    bit   full, empty, flush, irq_n, rd_data;
    exp_t e;
    cyc = bus; stb = bus; we = w; sel = s; dati = d;
    adr = ($urandom & 32'hFFFF_FFC3) | {26'b0, off, 2'b0};
    cti = 3'($urandom); bte = 2'($urandom);
    pv = v; psof = sf; pd = px;
    if (bus) begin
      e.is_rd = !w; e.val = m_read(off); e.name = $sformatf("read_off%0h", off);
      sb.push_back(e);
    end
    @(posedge clk);
    full    = (mq.size() == DEPTH);
    empty   = (mq.size() == 0);
    flush   = bus && w && off == 4'h0 && s[0] && d[1];
    rd_data = bus && !w && off == 4'h2;
    irq_n   = m_irq_en && ((m_thresh != 0 && mq.size() >= int'(m_thresh)) || m_ovf);
    if (bus && w && off == 4'h1) begin
      if (d[2]) m_ovf = 0;
      if (d[3]) m_sof = 0;
      if (d[4]) m_unf = 0;
    end
    if (v && m_en && full) m_ovf = 1;
    if (rd_data && empty) m_unf = 1;
    if (flush) mq.delete();
    else begin
      if (rd_data && !empty) void'(mq.pop_front());
      if (v && m_en && !full) begin
        mq.push_back({sf, px});
        if (sf) m_sof = 1;
      end
    end
    if (bus && w && off == 4'h0 && s[0]) begin
      m_en = d[0];
`ifdef WB_CAM_IRQ_EN
      m_irq_en = d[2];
`endif
    end
`ifdef WB_CAM_IRQ_EN
    if (bus && w && off == 4'h3) begin
      if (s[0]) m_thresh[7:0]  = d[7:0];
      if (s[1]) m_thresh[15:8] = d[15:8];
    end
`endif
    m_irq = irq_n;
    #1;
    cyc = 0; stb = 0; we = 0; pv = 0; psof = 0;
  endtask

  task automatic idle();
    step(0, 0, 4'h0, 32'h0, 4'h0, bg_v(), 1'($urandom), 16'($urandom));
  endtask

  // Request cycle followed by the ack cycle.
  task automatic bus(bit w, logic [3:0] off, logic [31:0] d, logic [3:0] s);
    step(1, w, off, d, s, bg_v(), 1'($urandom), 16'($urandom));
    idle();
  endtask

  task automatic pix(bit sf, logic [15:0] d);
    step(0, 0, 4'h0, 32'h0, 4'h0, 1'b1, sf, d);
  endtask

  task automatic pulse_reset();
    cyc = 0; stb = 0; rst = 1; pv = 1; psof = 1; pd = 16'($urandom);
    @(posedge clk);
    model_reset();
    #1;
    rst = 0; pv = 0; psof = 0;
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      req_at_edge = cyc && stb;
      @(negedge clk);
      if (mon_en) begin
        check("ack_timing", 32'(ack), 32'(req_at_edge));
        if (ack) begin
          if (sb.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL ack_unexpected: actual ack=1 required no outstanding request");
          end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_rd) check(mon_e.name, dato, mon_e.val);
          end
        end
        check("irq_o", 32'(irq), 32'(m_irq));
        check("pix_ready_o", 32'(pready), 32'(m_en && mq.size() < DEPTH));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: actual still running required finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int r;
    rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; dati = 0; sel = 0; cti = 0; bte = 0;
    pv = 0; psof = 0; pd = 0;
    @(posedge clk);
    pulse_reset();
    mon_en = 1;
    @(negedge clk);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat_o", dato, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_err_rty", {30'b0, err, rty}, 32'h0);

    // Reset register values, including an unmapped offset.
    bus(0, 4'h0, 0, 4'h0);
    bus(0, 4'h1, 0, 4'h0);
    bus(0, 4'h3, 0, 4'h0);
    bus(0, 4'h9, 0, 4'h0);

    // Three pixels, then drain past empty.
    bus(1, 4'h0, 32'h1, 4'hF);
    pix(1, 16'h1234); pix(0, 16'hABCD); pix(0, 16'h0001);
    bus(0, 4'h1, 0, 4'h0);
    repeat (4) bus(0, 4'h2, 0, 4'h0);
    bus(0, 4'h1, 0, 4'h0);

    // Overfill, then a DATA pop racing a pixel on a full FIFO.
    for (int i = 0; i < DEPTH + 2; i++) pix(1'($urandom), 16'($urandom));
    bus(0, 4'h1, 0, 4'h0);
    step(1, 0, 4'h2, 0, 4'h0, 1'b1, 1'b0, 16'h5555);
    idle();
    bus(0, 4'h1, 0, 4'h0);
    bus(1, 4'h1, 32'h1C, 4'hF);
    bus(0, 4'h1, 0, 4'h0);
    while (mq.size() > 0) bus(0, 4'h2, 0, 4'h0);

    // Threshold interrupt around level 4.
    bus(1, 4'h3, 32'h4, 4'hF);
    bus(1, 4'h0, 32'h5, 4'hF);
    repeat (5) begin pix(0, 16'($urandom)); idle(); end
    bus(0, 4'h2, 0, 4'h0);
    bus(0, 4'h2, 0, 4'h0);
    bus(0, 4'h3, 0, 4'h0);
    bus(0, 4'h0, 0, 4'h0);

    // Random traffic with background pixels.
    bg_rate = 50;
    repeat (300) begin
      r = $urandom_range(99);
      if (r < 45)      bus(0, 4'h2, 0, 4'h0);
      else if (r < 58) bus(0, 4'h1, 0, 4'h0);
      else if (r < 66) bus(1, 4'h1, $urandom, 4'($urandom));
      else if (r < 74) bus(1, 4'h0, {$urandom} & 32'hFFFF_FFF8 |
                                    {29'b0, 1'($urandom), 1'($urandom_range(9) == 0),
                                     1'($urandom_range(9) != 0)}, 4'($urandom));
      else if (r < 80) bus(1, 4'h3, 32'($urandom_range(12)) | ({$urandom} & 32'hFFFF_0000),
                           4'($urandom));
      else if (r < 86) bus(0, 4'($urandom_range(3)), 0, 4'h0);
      else if (r < 90) bus(w_rand(), 4'($urandom_range(4, 15)), $urandom, 4'hF);
      else repeat ($urandom_range(1, 8)) pix(1'($urandom), 16'($urandom));
    end
    bg_rate = 0;

    // FLUSH with 10 entries and a same-cycle push.
    bus(1, 4'h0, 32'h3, 4'hF);
    for (int i = 0; i < 10; i++) pix(1'b0, 16'(i * 3 + 1));
    bus(0, 4'h1, 0, 4'h0);
    step(1, 1, 4'h0, 32'h3, 4'hF, 1'b1, 1'b0, 16'hBEEF);
    idle();
    bus(0, 4'h1, 0, 4'h0);
    bus(0, 4'h2, 0, 4'h0);

    // Mid-stream reset.
    bus(1, 4'h3, 32'h7, 4'hF);
    bus(1, 4'h0, 32'h5, 4'hF);
    for (int i = 0; i < 6; i++) pix(1'($urandom), 16'($urandom));
    pulse_reset();
    bus(0, 4'h0, 0, 4'h0);
    bus(0, 4'h1, 0, 4'h0);
    bus(0, 4'h2, 0, 4'h0);
    bus(0, 4'h3, 0, 4'h0);

    repeat (3) idle();
    if (sb.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL ack_missing: actual %0d requests unacked required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic bit w_rand();
    return 1'($urandom);
  endfunction
endmodule
